// File: rtl/dmac_ch_engine.sv
// dmac_ch_engine: per-channel DMA transfer engine acting as an AHB-Lite master.
// Picks a requesting channel round-robin, then moves one 32-bit word at a time as
// a single read followed by a single write.
// Ports:
//   HCLK, HRESETn                clock, synchronous active-low reset
//   ch_en/ch_target/ch_size      per-channel enable, direction, word count (slice i = channel i)
//   ch_sour/ch_dest              per-channel source / destination byte addresses
//   HADDR_M..HWDATA_M            AHB-Lite master address/control/write data (registered)
//   HRDATA_M, HREADY_M           AHB-Lite read data and ready from the slave
//   ch_done                      one-cycle completion pulse per channel
//   busy, cur_ch                 engine active flag and granted channel index
module dmac_ch_engine #(
    parameter int unsigned NCH = 4,
    parameter int unsigned SZW = 10
) (
    input  logic                                  HCLK,
    input  logic                                  HRESETn,
    input  logic [NCH-1:0]                        ch_en,
    input  logic [NCH-1:0]                        ch_target,
    input  logic [NCH*SZW-1:0]                    ch_size,
    input  logic [NCH*32-1:0]                     ch_sour,
    input  logic [NCH*32-1:0]                     ch_dest,
    output logic [31:0]                           HADDR_M,
    output logic [1:0]                            HTRANS_M,
    output logic                                  HWRITE_M,
    output logic [2:0]                            HSIZE_M,
    output logic [31:0]                           HWDATA_M,
    input  logic [31:0]                           HRDATA_M,
    input  logic                                  HREADY_M,
    output logic [NCH-1:0]                        ch_done,
    output logic                                  busy,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cur_ch
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW  = 32;
    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CHW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]     cur_ch_q, cur_ch_d;
    logic [SZW-1:0]     size_q, size_d;
    logic [SZW-1:0]     word_cnt_q, word_cnt_d;
    logic [AW-1:0]      src_q, src_d;
    logic [AW-1:0]      dst_q, dst_d;
    logic               tgt_q, tgt_d;
    logic [31:0]        data_buf_q, data_buf_d;
    logic [NCH-1:0]     done_flag_q, done_flag_d;
    logic [NCH-1:0]     done_set;
    logic [AW-1:0]      haddr_q, haddr_d;
    logic [1:0]         htrans_q, htrans_d;
    logic               hwrite_q, hwrite_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic [NCH-1:0]     ch_done_q, ch_done_d;
    logic               busy_q, busy_d;

    logic [NCH-1:0]     req;
    logic               grant_vld;
    logic [CHW-1:0]     grant_idx;
    logic [31:0]        pos;

    // Round-robin search upward from rr_ptr; scanning downward lets the nearest hit win.
    always_comb begin
        req       = ch_en & ~done_flag_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        pos       = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            pos = (32'(rr_ptr_q) + 32'(k)) % 32'(NCH);
            if (req[pos[CHW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = pos[CHW-1:0];
            end
        end
    end

    // Next-state logic; bus outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_ch_d   = cur_ch_q;
        size_d     = size_q;
        word_cnt_d = word_cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        tgt_d      = tgt_q;
        data_buf_d = data_buf_q;
        done_set   = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    cur_ch_d   = grant_idx;
                    rr_ptr_d   = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
                    size_d     = ch_size[32'(grant_idx) * SZW +: SZW];
                    src_d      = ch_sour[32'(grant_idx) * 32 +: 32];
                    dst_d      = ch_dest[32'(grant_idx) * 32 +: 32];
                    tgt_d      = ch_target[grant_idx];
                    word_cnt_d = '0;
                    state_d    = (size_d == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: if (HREADY_M) state_d = S_RD_D;
            S_RD_D: begin
                if (HREADY_M) begin
                    data_buf_d = HRDATA_M;
                    state_d    = S_WR_A;
                end
            end
            S_WR_A: if (HREADY_M) state_d = S_WR_D;
            S_WR_D: begin
                if (HREADY_M) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (tgt_q) dst_d = dst_q + 32'd4;
                    else       src_d = src_q + 32'd4;
                    // Enable drop only aborts between words; completion takes priority.
                    if (word_cnt_d == size_q)  state_d = S_DONE;
                    else if (!ch_en[cur_ch_q]) state_d = S_IDLE;
                    else                       state_d = S_RD_A;
                end
            end
            S_DONE: begin
                done_set[cur_ch_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A cleared enable forgets completion so the channel can be rerun.
        done_flag_d = ch_en & (done_flag_q | done_set);

        htrans_d  = (state_d == S_RD_A || state_d == S_WR_A) ? TR_NONSEQ : TR_IDLE;
        hwrite_d  = (state_d == S_WR_A || state_d == S_WR_D);
        haddr_d   = haddr_q;
        if (state_d == S_RD_A) haddr_d = src_d;
        if (state_d == S_WR_A) haddr_d = dst_d;
        hwdata_d  = hwdata_q;
        if (state_d == S_WR_A) hwdata_d = data_buf_d;
        busy_d    = (state_d != S_IDLE);
        ch_done_d = '0;
        if (state_d == S_DONE) ch_done_d[cur_ch_d] = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cur_ch_q    <= '0;
            size_q      <= '0;
            word_cnt_q  <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            tgt_q       <= 1'b0;
            data_buf_q  <= '0;
            done_flag_q <= '0;
            haddr_q     <= '0;
            htrans_q    <= TR_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            ch_done_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_ch_q    <= cur_ch_d;
            size_q      <= size_d;
            word_cnt_q  <= word_cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            tgt_q       <= tgt_d;
            data_buf_q  <= data_buf_d;
            done_flag_q <= done_flag_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            ch_done_q   <= ch_done_d;
            busy_q      <= busy_d;
        end
    end

    assign HADDR_M  = haddr_q;
    assign HTRANS_M = htrans_q;
    assign HWRITE_M = hwrite_q;
    assign HSIZE_M  = 3'b010;
    assign HWDATA_M = hwdata_q;
    assign ch_done  = ch_done_q;
    assign busy     = busy_q;
    assign cur_ch   = cur_ch_q;

endmodule
